// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32 load/store unit: access sizes, FSM states,
// and helpers that place store data and byte enables on the 32-bit bus.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  // Size 11 has no legal encoding, so it is reported the same way as a misaligned access.
  function automatic logic misaligned(size_e sz, logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] wstrb_of(size_e sz, logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across all lanes; the byte enables select the real target.
  function automatic logic [XLEN-1:0] lane_wdata(size_e sz, logic [XLEN-1:0] wd);
    case (sz)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rv32_if.sv
// Memory-side valid/ready bus of the load/store unit.
// The LSU is the master; the memory slave answers every request with one response.
interface lsu_rv32_if;
  import lsu_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );

endinterface

// File: rtl/lsu_load_ext.sv
// Selects the addressed byte/half/word out of a 32-bit read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  size_e           size,
  input  logic            is_sign,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    data    = shifted;
    case (size)
      SZ_B:    data = {{24{is_sign & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{is_sign & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_rv32.sv
// RV32 load/store unit: one memory op at a time from execute onto a valid/ready
// memory bus, with misaligned accesses answered locally without a bus cycle.
module lsu_rv32
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic                req_is_load,
  input  logic                req_is_store,
  input  logic [1:0]          req_size,
  input  logic                req_is_sign,
  output logic                ls_valid,
  input  logic                ls_ready,
  output logic [DATA_LEN-1:0] load_data,
  output logic                misalign,
  lsu_rv32_if.master          mem
);

  state_e          state;
  logic [1:0]      off_q;
  size_e           size_q;
  logic            sign_q;
  logic            load_q;
  logic [XLEN-1:0] ext_data;

  lsu_load_ext u_load_ext (
    .rdata   (mem.mem_rdata),
    .off     (off_q),
    .size    (size_q),
    .is_sign (sign_q),
    .data    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      req_ready         <= 1'b1;
      ls_valid          <= 1'b0;
      misalign          <= 1'b0;
      load_data         <= '0;
      off_q             <= 2'b00;
      size_q            <= SZ_B;
      sign_q            <= 1'b0;
      load_q            <= 1'b0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_we        <= 1'b0;
      mem.mem_wstrb     <= 4'b0000;
      mem.mem_wdata     <= '0;
      mem.mem_rsp_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Ops flagged as neither load nor store are consumed and silently dropped.
          if (req_valid && req_ready && (req_is_load || req_is_store)) begin
            off_q     <= req_addr[1:0];
            size_q    <= size_e'(req_size);
            sign_q    <= req_is_sign;
            load_q    <= req_is_load;
            req_ready <= 1'b0;
            if (misaligned(size_e'(req_size), req_addr[1:0])) begin
              state     <= DONE;
              ls_valid  <= 1'b1;
              misalign  <= 1'b1;
              load_data <= '0;
            end else begin
              state             <= REQ;
              mem.mem_req_valid <= 1'b1;
              mem.mem_addr      <= {req_addr[DATA_LEN-1:2], 2'b00};
              mem.mem_we        <= ~req_is_load;
              mem.mem_wstrb     <= req_is_load ? 4'b0000 : wstrb_of(size_e'(req_size), req_addr[1:0]);
              mem.mem_wdata     <= req_is_load ? '0 : lane_wdata(size_e'(req_size), req_wdata);
            end
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            state             <= WAIT;
            mem.mem_req_valid <= 1'b0;
            mem.mem_rsp_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (mem.mem_rsp_valid) begin
            state             <= DONE;
            mem.mem_rsp_ready <= 1'b0;
            ls_valid          <= 1'b1;
            load_data         <= load_q ? ext_data : '0;
          end
        end
        DONE: begin
          if (ls_ready) begin
            state     <= IDLE;
            ls_valid  <= 1'b0;
            misalign  <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rv32.sv
// Bench for lsu_rv32: directed vector table, stall/reset sequences, and random
// ops checked against a byte-level reference model of the load/store rules.
module tb_lsu_rv32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_is_load;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_is_sign;
  logic        ls_valid;
  logic        ls_ready;
  logic [31:0] load_data;
  logic        misalign;

  int n_vec = 0;
  int n_err = 0;

  lsu_rv32_if bus();

  lsu_rv32 #(.DATA_LEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_is_load  (req_is_load),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_is_sign  (req_is_sign),
    .ls_valid     (ls_valid),
    .ls_ready     (ls_ready),
    .load_data    (load_data),
    .misalign     (misalign),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    logic [31:0] e_data;
    logic        e_mis;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req_ready"},     32'(req_ready),         32'd1);
    chk({tag, ".ls_valid"},      32'(ls_valid),          32'd0);
    chk({tag, ".misalign"},      32'(misalign),          32'd0);
    chk({tag, ".load_data"},     load_data,              32'd0);
    chk({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, ".mem_we"},        32'(bus.mem_we),        32'd0);
    chk({tag, ".mem_rsp_ready"}, 32'(bus.mem_rsp_ready), 32'd0);
    chk({tag, ".mem_addr"},      bus.mem_addr,           32'd0);
    chk({tag, ".mem_wdata"},     bus.mem_wdata,          32'd0);
    chk({tag, ".mem_wstrb"},     32'(bus.mem_wstrb),     32'd0);
  endtask

  // Reference model: works in byte counts and byte lanes rather than encodings.
  function automatic vec_t model(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic ld, input logic st, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] rdata);
    vec_t   v;
    int     nb;
    int     off;
    longint val;
    v = '0;
    v.addr = addr; v.wdata = wdata; v.ld = ld; v.st = st;
    v.size = size; v.sgn = sgn; v.rdata = rdata;
    off = int'(addr % 4);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    v.e_addr = addr - 32'(off);
    v.e_we   = st && !ld;
    if (nb == 0) v.e_mis = 1'b1;
    else         v.e_mis = (off % nb) != 0;
    if (!v.e_mis) begin
      if (v.e_we) begin
        for (int i = 0; i < 4; i++) begin
          if (i >= off && i < off + nb) v.e_strb[i] = 1'b1;
          v.e_wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
        end
      end else begin
        val = longint'((64'(rdata) >> (8*off)) & ((64'd1 << (8*nb)) - 64'd1));
        if (sgn && nb < 4 && val >= longint'(64'd1 << (8*nb-1)))
          val = val - longint'(64'd1 << (8*nb));
        v.e_data = val[31:0];
      end
    end
    return v;
  endfunction

  // Drives one op through the LSU with the given bus/consumer stall counts and
  // checks every cycle of it; stray responses are injected while the request stalls.
  task automatic run_op(input vec_t v, input int req_lat, input int rsp_lat,
                        input int ls_lat, input string tag);
    @(negedge clk);
    chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata;
    req_is_load = v.ld; req_is_store = v.st; req_size = v.size; req_is_sign = v.sgn;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (!v.ld && !v.st) begin
      chk({tag, ".drop_ready"},   32'(req_ready),         32'd1);
      chk({tag, ".drop_lsvalid"}, 32'(ls_valid),          32'd0);
      chk({tag, ".drop_memreq"},  32'(bus.mem_req_valid), 32'd0);
      return;
    end
    chk({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    if (!v.e_mis) begin
      for (int c = 0; c <= req_lat; c++) begin
        chk({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
        chk({tag, ".mem_addr"},      bus.mem_addr,           v.e_addr);
        chk({tag, ".mem_we"},        32'(bus.mem_we),        32'(v.e_we));
        chk({tag, ".mem_wstrb"},     32'(bus.mem_wstrb),     32'(v.e_strb));
        if (v.e_we) chk({tag, ".mem_wdata"}, bus.mem_wdata, v.e_wdata);
        chk({tag, ".req_lsvalid"},   32'(ls_valid),          32'd0);
        chk({tag, ".req_rspready"},  32'(bus.mem_rsp_ready), 32'd0);
        if (c == req_lat) bus.mem_req_ready = 1'b1;
        else begin bus.mem_rsp_valid = 1'b1; bus.mem_rdata = $urandom; end
        @(negedge clk);
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      end
      for (int c = 0; c <= rsp_lat; c++) begin
        chk({tag, ".wait_memreq"},   32'(bus.mem_req_valid), 32'd0);
        chk({tag, ".wait_rspready"}, 32'(bus.mem_rsp_ready), 32'd1);
        chk({tag, ".wait_lsvalid"},  32'(ls_valid),          32'd0);
        chk({tag, ".wait_ready"},    32'(req_ready),         32'd0);
        if (c == rsp_lat) begin bus.mem_rsp_valid = 1'b1; bus.mem_rdata = v.rdata; end
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0; bus.mem_rdata = $urandom;
      end
    end
    for (int c = 0; c <= ls_lat; c++) begin
      chk({tag, ".ls_valid"},    32'(ls_valid),          32'd1);
      chk({tag, ".misalign"},    32'(misalign),          32'(v.e_mis));
      chk({tag, ".load_data"},   load_data,              v.e_data);
      chk({tag, ".done_ready"},  32'(req_ready),         32'd0);
      chk({tag, ".done_memreq"}, 32'(bus.mem_req_valid), 32'd0);
      if (c == ls_lat) ls_ready = 1'b1;
      @(negedge clk);
      ls_ready = 1'b0;
    end
    chk({tag, ".end_lsvalid"}, 32'(ls_valid),  32'd0);
    chk({tag, ".end_ready"},   32'(req_ready), 32'd1);
    chk({tag, ".end_mis"},     32'(misalign),  32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_is_load = 1'b0;
    req_is_store = 1'b0; req_size = 2'b00; req_is_sign = 1'b0; ls_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;

    //            addr          wdata         ld    st    size   sgn   rdata         e_data        mis   we    strb     e_wdata       e_addr
    tbl[0]  = '{32'h8000_0003, 32'h0,        1'b1, 1'b0, 2'b00, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h8000_0000};
    tbl[1]  = '{32'h8000_0002, 32'h0,        1'b1, 1'b0, 2'b01, 1'b0, 32'hBEEF_0000, 32'h0000_BEEF, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h8000_0000};
    tbl[2]  = '{32'h8000_0002, 32'h0,        1'b1, 1'b0, 2'b01, 1'b1, 32'hBEEF_0000, 32'hFFFF_BEEF, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h8000_0000};
    tbl[3]  = '{32'h8000_0001, 32'h0000_00AB, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1234_5678, 32'h0,        1'b0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h8000_0000};
    tbl[4]  = '{32'h8000_0002, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 32'h1111_1111, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[5]  = '{32'h0000_1002, 32'h1234_CDEF, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 4'b1100, 32'hCDEF_CDEF, 32'h0000_1000};
    tbl[6]  = '{32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1004};
    tbl[7]  = '{32'h0000_0010, 32'h0,        1'b1, 1'b0, 2'b00, 1'b0, 32'h1234_5680, 32'h0000_0080, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0010};
    tbl[8]  = '{32'h0000_0020, 32'h0,        1'b1, 1'b0, 2'b10, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0020};
    tbl[9]  = '{32'h0000_0041, 32'h0,        1'b1, 1'b0, 2'b01, 1'b1, 32'h2222_2222, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[10] = '{32'h0000_0040, 32'h0,        1'b1, 1'b0, 2'b11, 1'b0, 32'h3333_3333, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[11] = '{32'h0000_0052, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b00, 1'b1, 32'h007F_0000, 32'h0000_007F, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0050};
    tbl[12] = '{32'h0000_0003, 32'h0000_0001, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[13] = '{32'h0000_0001, 32'h0,        1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_8000, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0000};
    tbl[14] = '{32'h0000_0003, 32'h1234_5678, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 4'b1000, 32'h7878_7878, 32'h0000_0000};
    tbl[15] = '{32'h0000_0000, 32'h0,        1'b1, 1'b0, 2'b01, 1'b1, 32'h1234_7FFF, 32'h0000_7FFF, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0000};

    repeat (3) @(negedge clk);
    chk_reset("reset_held");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset_rel");

    // Zero-wait pass first so ls_valid timing lands at T+3 / T+1, then with stalls.
    for (int i = 0; i < 16; i++) run_op(tbl[i], 0, 0, 0, $sformatf("tbl%0d", i));
    for (int i = 0; i < 16; i++) run_op(tbl[i], i % 3, (i + 1) % 3, i % 2, $sformatf("tbls%0d", i));

    run_op(tbl[1], 3, 2, 2, "stall_lhu");
    run_op(model(32'h0000_0200, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0), 0, 0, 0, "dropped");

    // Reset while waiting for a store acknowledge; a late response must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0104; req_wdata = 32'h55AA_55AA;
    req_is_load = 1'b0; req_is_store = 1'b1; req_size = 2'b10; req_is_sign = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw.mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("rstw.in_wait", 32'(bus.mem_rsp_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rstw");
    for (int c = 0; c < 2; c++) begin
      bus.mem_rsp_valid = 1'b1; bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("rstw.late_lsvalid", 32'(ls_valid),          32'd0);
      chk("rstw.late_ready",   32'(req_ready),         32'd1);
      chk("rstw.late_rspr",    32'(bus.mem_rsp_ready), 32'd0);
    end
    bus.mem_rsp_valid = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [1:0]  sz;
      logic        ld;
      logic        st;
      logic        sg;
      a  = $urandom; wd = $urandom; rd = $urandom;
      sz = 2'($urandom_range(0, 3));
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      run_op(model(a, wd, ld, st, sz, sg, rd), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
